// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave shift engine.
package spi_slv_pkg;

    // Shallowest synchroniser that still gives metastability settling time
    localparam int SPI_SYNC_STG_MIN = 2;

    // Storage width for the latched frame length (covers DW up to 128)
    localparam int SPI_FLEN_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // Per-transfer configuration, frozen when CSn falls
    typedef struct packed {
        logic                  cpol;
        logic                  cpha;
        logic                  lsbf;
        logic [SPI_FLEN_W-1:0] flen;
    } spi_cfg_t;

endpackage

// File: rtl/spi_slv_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with rise/fall detection
// on the synchronised level.
module spi_slv_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              dly_reg;

    // Shift the pin through the chain; keep one extra copy for edge detection
    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {STAGES{RST_VAL}};
            dly_reg  <= RST_VAL;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
            dly_reg  <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = level & ~dly_reg;
    assign fall  = ~level & dly_reg;

endmodule

// File: rtl/spi_slv_core.sv
// SPI slave shift engine: all four CPOL/CPHA modes, MSB/LSB first, runtime
// frame length, oversampled pins, valid/ready TX and RX word interfaces.
module spi_slv_core
    import spi_slv_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            SYNC_STG = 2,
    parameter logic [DW-1:0] TX_IDLE  = '0,
    localparam int           LW       = $clog2(DW)
) (
    input  logic          PCLK,
    input  logic          srst,
    input  logic          cfg_en,
    input  logic          cfg_cpol,
    input  logic          cfg_cpha,
    input  logic          cfg_lsbf,
    input  logic [LW-1:0] cfg_flen,
    input  logic          SCK,
    input  logic          CSn,
    input  logic          MOSI,
    output logic          MISO,
    output logic          MISO_OE,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          cmpl_pls,
    output logic          abrt_pls,
    output logic          tx_udf,
    output logic          rx_ovf,
    output logic          busy
);

    localparam int SYNC_DEPTH = (SYNC_STG < SPI_SYNC_STG_MIN) ? SPI_SYNC_STG_MIN : SYNC_STG;

    // Pin bundle: bit 0 = SCK, bit 1 = CSn (idles high), bit 2 = MOSI
    logic [2:0] pin_vec;
    logic [2:0] lvl_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pin_vec = {MOSI, CSn, SCK};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            spi_slv_sync #(
                .STAGES  (SYNC_DEPTH),
                .RST_VAL (gi == 1)
            ) u_sync (
                .clk   (PCLK),
                .srst  (srst),
                .d     (pin_vec[gi]),
                .level (lvl_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;
    logic mosi_s;

    assign sck_rise = rise_vec[0];
    assign sck_fall = fall_vec[0];
    assign cs_rise  = rise_vec[1];
    assign cs_fall  = fall_vec[1];
    assign mosi_s   = lvl_vec[2];

    spi_state_e      state_reg;
    spi_cfg_t        cfg_reg;
    logic [DW-1:0]   tx_sr_reg;
    logic [DW-1:0]   rx_sr_reg;
    logic [LW-1:0]   cnt_reg;
    logic            first_lead_reg;
    logic            hold_reg;
    logic [DW-1:0]   rx_data_reg;
    logic            rx_valid_reg;
    logic            cmpl_pls_reg;
    logic            abrt_pls_reg;
    logic            rx_ovf_reg;

    logic [LW-1:0]         flen_w;
    logic [SPI_FLEN_W-1:0] flen_ext;
    logic                  lead_evt;
    logic                  trail_evt;
    logic                  smp_evt;
    logic                  shf_evt;
    logic [DW-1:0]         rx_shift;
    logic [DW-1:0]         tx_shift;

    assign flen_w = cfg_reg.flen[LW-1:0];

    // Widen the runtime frame length into the stored config field
    always_comb begin
        flen_ext         = '0;
        flen_ext[LW-1:0] = cfg_flen;
    end

    // Classify synced SCK edges against the latched mode
    always_comb begin
        lead_evt  = cfg_reg.cpol ? sck_fall : sck_rise;
        trail_evt = cfg_reg.cpol ? sck_rise : sck_fall;
        smp_evt   = cfg_reg.cpha ? trail_evt : lead_evt;
        shf_evt   = cfg_reg.cpha ? lead_evt : trail_evt;
    end

    // Next shift-register values; LSB-first enters at bit flen and walks down to 0
    always_comb begin
        rx_shift = '0;
        if (cfg_reg.lsbf) begin
            rx_shift         = rx_sr_reg >> 1;
            rx_shift[flen_w] = mosi_s;
        end else begin
            rx_shift = {rx_sr_reg[DW-2:0], mosi_s};
        end
        tx_shift = cfg_reg.lsbf ? (tx_sr_reg >> 1) : (tx_sr_reg << 1);
    end

    // Transfer FSM, shift registers, RX handoff and status pulses
    always_ff @(posedge PCLK) begin
        if (srst) begin
            state_reg      <= ST_IDLE;
            cfg_reg        <= '0;
            tx_sr_reg      <= '0;
            rx_sr_reg      <= '0;
            cnt_reg        <= '0;
            first_lead_reg <= 1'b0;
            hold_reg       <= 1'b0;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            cmpl_pls_reg   <= 1'b0;
            abrt_pls_reg   <= 1'b0;
            rx_ovf_reg     <= 1'b0;
        end else begin
            cmpl_pls_reg <= 1'b0;
            abrt_pls_reg <= 1'b0;
            rx_ovf_reg   <= 1'b0;
            if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (cs_fall && cfg_en) begin
                        cfg_reg   <= spi_cfg_t'{cpol: cfg_cpol, cpha: cfg_cpha,
                                                lsbf: cfg_lsbf, flen: flen_ext};
                        state_reg <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (cs_rise) begin
                        // Popped word is dropped along with the frame
                        abrt_pls_reg <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end else begin
                        tx_sr_reg      <= tx_valid ? tx_data : TX_IDLE;
                        rx_sr_reg      <= '0;
                        cnt_reg        <= '0;
                        first_lead_reg <= cfg_reg.cpha;
                        hold_reg       <= 1'b0;
                        state_reg      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Only a partially received word counts as an abort
                        if (cnt_reg != '0) begin
                            abrt_pls_reg <= 1'b1;
                        end
                        cnt_reg   <= '0;
                        hold_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else if (hold_reg) begin
                        // cpha=0: last bit stays on MISO until its trailing edge
                        if (trail_evt) begin
                            state_reg <= ST_LOAD;
                        end
                    end else begin
                        if (smp_evt) begin
                            if (cnt_reg == flen_w) begin
                                cmpl_pls_reg <= 1'b1;
                                cnt_reg      <= '0;
                                if (!rx_valid_reg || rx_ready) begin
                                    rx_data_reg  <= rx_shift;
                                    rx_valid_reg <= 1'b1;
                                end else begin
                                    rx_ovf_reg <= 1'b1;
                                end
                                if (cfg_reg.cpha) begin
                                    state_reg <= ST_LOAD;
                                end else begin
                                    hold_reg <= 1'b1;
                                end
                            end else begin
                                rx_sr_reg <= rx_shift;
                                cnt_reg   <= cnt_reg + 1'b1;
                            end
                        end
                        if (shf_evt) begin
                            // cpha=1: the first bit is already on MISO at the first leading edge
                            if (first_lead_reg) begin
                                first_lead_reg <= 1'b0;
                            end else begin
                                tx_sr_reg <= tx_shift;
                            end
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign MISO     = (state_reg == ST_SHIFT) &&
                      (cfg_reg.lsbf ? tx_sr_reg[0] : tx_sr_reg[flen_w]);
    assign MISO_OE  = (state_reg != ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);
    assign tx_ready = (state_reg == ST_LOAD) && tx_valid;
    assign tx_udf   = (state_reg == ST_LOAD) && !tx_valid;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign cmpl_pls = cmpl_pls_reg;
    assign abrt_pls = abrt_pls_reg;
    assign rx_ovf   = rx_ovf_reg;

    // Sync outputs and config bits that this engine has no use for
    logic unused_sync;
    assign unused_sync = ^{lvl_vec[1:0], rise_vec[2], fall_vec[2],
                           cfg_reg.flen[SPI_FLEN_W-1:LW]};

endmodule

// File: tb/tb_spi_slv_core.sv
// Bench for spi_slv_core: a behavioural SPI master drives frames and a
// word-level model predicts MISO words, RX words and status pulse counts.
module tb_spi_slv_core;

    localparam int          DW       = 32;
    localparam int          LW       = $clog2(DW);
    localparam int          SYNC_STG = 2;
    localparam logic [31:0] TX_IDLE  = 32'h0000_00FF;
    localparam int          HP       = 8;
    localparam int          SETUP    = 8;

    logic          PCLK = 1'b0;
    logic          srst = 1'b1;
    logic          cfg_en = 1'b1;
    logic          cfg_cpol = 1'b0;
    logic          cfg_cpha = 1'b0;
    logic          cfg_lsbf = 1'b0;
    logic [LW-1:0] cfg_flen = '0;
    logic          SCK = 1'b0;
    logic          CSn = 1'b1;
    logic          MOSI = 1'b0;
    logic          MISO;
    logic          MISO_OE;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b1;
    logic          cmpl_pls;
    logic          abrt_pls;
    logic          tx_udf;
    logic          rx_ovf;
    logic          busy;

    spi_slv_core #(
        .DW       (DW),
        .SYNC_STG (SYNC_STG),
        .TX_IDLE  (TX_IDLE)
    ) dut (
        .PCLK     (PCLK),
        .srst     (srst),
        .cfg_en   (cfg_en),
        .cfg_cpol (cfg_cpol),
        .cfg_cpha (cfg_cpha),
        .cfg_lsbf (cfg_lsbf),
        .cfg_flen (cfg_flen),
        .SCK      (SCK),
        .CSn      (CSn),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .MISO_OE  (MISO_OE),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .cmpl_pls (cmpl_pls),
        .abrt_pls (abrt_pls),
        .tx_udf   (tx_udf),
        .rx_ovf   (rx_ovf),
        .busy     (busy)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // External FIFO models and pulse counters
    logic [31:0] tx_q[$];
    logic [31:0] rx_got[$];
    logic [31:0] pop_tmp;
    logic        pop_pend = 1'b0;
    int cmpl_cnt = 0, abrt_cnt = 0, udf_cnt = 0, ovf_cnt = 0, pop_cnt = 0;

    // Master-side view of the transfer mode
    logic m_cpol = 1'b0, m_cpha = 1'b0, m_lsbf = 1'b0;
    int   m_flen = 7;

    logic [31:0] mo_w[4];
    logic [31:0] mi_w[4];
    logic [31:0] txw[4];
    logic [31:0] scratch;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic clr_counts();
        cmpl_cnt = 0; abrt_cnt = 0; udf_cnt = 0; ovf_cnt = 0; pop_cnt = 0;
        rx_got.delete();
    endtask

    // Sample DUT outputs mid-cycle; pop the TX FIFO the cycle after the DUT took its word
    always @(negedge PCLK) begin
        if (pop_pend) begin
            pop_tmp  = tx_q.pop_front();
            pop_pend = 1'b0;
        end
        if (tx_ready) begin
            pop_cnt++;
            pop_pend = 1'b1;
        end
        if (cmpl_pls) cmpl_cnt++;
        if (abrt_pls) abrt_cnt++;
        if (tx_udf)   udf_cnt++;
        if (rx_ovf)   ovf_cnt++;
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        tx_valid = (tx_q.size() > 0);
        tx_data  = (tx_q.size() > 0) ? tx_q[0] : '0;
    end

    // One frame (or its first nbits bits) as an SPI master under an asserted CSn
    task automatic spi_frame(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        int b;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            b = m_lsbf ? i : (m_flen - i);
            if (!m_cpha) begin
                MOSI = mo[b];
                wait_clk(HP);
                SCK = ~m_cpol;
                mi[b] = MISO;
                wait_clk(HP);
                SCK = m_cpol;
            end else begin
                wait_clk(HP);
                SCK = ~m_cpol;
                MOSI = mo[b];
                wait_clk(HP);
                SCK = m_cpol;
                mi[b] = MISO;
            end
        end
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic lsbf, input int flen);
        m_cpol = mode[1]; m_cpha = mode[0]; m_lsbf = lsbf; m_flen = flen;
        cfg_cpol = mode[1]; cfg_cpha = mode[0]; cfg_lsbf = lsbf; cfg_flen = LW'(flen);
        SCK = mode[1];
    endtask

    // nf frames under one CSn, ntx words preloaded in the TX FIFO, then check against the model
    task automatic run_burst(input logic [1:0] mode, input logic lsbf, input int flen,
                             input int nf, input int ntx);
        logic [31:0] msk;
        logic [31:0] exp_w;
        logic [31:0] got_w;
        int loads;
        int exp_pop;
        msk = 32'((64'd1 << (flen + 1)) - 64'd1);
        @(posedge PCLK);
        tx_q.delete();
        for (int k = 0; k < ntx; k++) tx_q.push_back(txw[k]);
        clr_counts();
        set_mode(mode, lsbf, flen);
        wait_clk(6);
        CSn = 1'b0;
        wait_clk(SETUP);
        // Config inputs are frozen at CSn fall; disturbing them must change nothing
        cfg_cpol = 1'($urandom); cfg_cpha = 1'($urandom);
        cfg_lsbf = 1'($urandom); cfg_flen = LW'($urandom);
        for (int f = 0; f < nf; f++) begin
            spi_frame(mo_w[f], flen + 1, mi_w[f]);
            $display("xact mode=%0d lsbf=%0d flen=%0d mosi=%h miso=%h", mode, lsbf, flen,
                     mo_w[f] & msk, mi_w[f]);
        end
        wait_clk(HP);
        CSn = 1'b1;
        wait_clk(12);

        // After every completed frame the engine reloads, so nf+1 loads in total
        loads   = nf + 1;
        exp_pop = (ntx < loads) ? ntx : loads;
        for (int f = 0; f < nf; f++) begin
            exp_w = (f < ntx) ? (txw[f] & msk) : (TX_IDLE & msk);
            chk("miso_word", mi_w[f], exp_w);
        end
        if (rx_ready) begin
            chk("rx_count", 32'(rx_got.size()), 32'(nf));
            for (int f = 0; f < nf; f++) begin
                got_w = (f < rx_got.size()) ? rx_got[f] : ~(mo_w[f] & msk);
                chk("rx_word", got_w, mo_w[f] & msk);
            end
        end else begin
            chk("rx_keep", rx_data, mo_w[0] & msk);
            chk("rx_ovf_count", 32'(ovf_cnt), 32'(nf - 1));
        end
        chk("cmpl_count", 32'(cmpl_cnt), 32'(nf));
        chk("pop_count", 32'(pop_cnt), 32'(exp_pop));
        chk("udf_count", 32'(udf_cnt), 32'(loads - exp_pop));
        chk("abrt_count", 32'(abrt_cnt), 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        wait_clk(4);
        chk("reset_flags", {23'd0, MISO, MISO_OE, tx_ready, tx_udf, rx_valid,
                            cmpl_pls, abrt_pls, rx_ovf, busy}, 32'd0);
        chk("reset_rx_data", rx_data, 32'd0);
        srst = 1'b0;
        wait_clk(4);

        // Mode 0, MSB first, 8 bits
        rx_ready = 1'b1;
        txw[0] = 32'h3C; mo_w[0] = 32'hA5;
        run_burst(2'd0, 1'b0, 7, 1, 1);

        // Mode 3, LSB first, 16 bits
        txw[0] = 32'hBEEF; mo_w[0] = 32'h1234;
        run_burst(2'd3, 1'b1, 15, 1, 1);

        // Back-to-back, mode 1, three 8-bit frames
        txw[0] = 32'hA1; txw[1] = 32'hB2; txw[2] = 32'hC3;
        mo_w[0] = 32'h01; mo_w[1] = 32'h02; mo_w[2] = 32'h03;
        run_burst(2'd1, 1'b0, 7, 3, 3);

        // Underrun and overrun: empty TX FIFO, RX consumer stalled
        rx_ready = 1'b0;
        mo_w[0] = 32'h5A; mo_w[1] = 32'hC7;
        run_burst(2'd0, 1'b0, 7, 2, 0);
        rx_ready = 1'b1;
        wait_clk(3);
        chk("rx_drain", {31'd0, rx_valid}, 32'd0);

        // Abort after 5 of 8 bits
        @(posedge PCLK);
        tx_q.delete();
        tx_q.push_back(32'h55);
        clr_counts();
        set_mode(2'd0, 1'b0, 7);
        wait_clk(6);
        CSn = 1'b0;
        wait_clk(SETUP);
        spi_frame(32'hE7, 5, scratch);
        CSn = 1'b1;
        wait_clk(SYNC_STG + 2);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        wait_clk(10);
        chk("abort_pulse", 32'(abrt_cnt), 32'd1);
        chk("abort_cmpl", 32'(cmpl_cnt), 32'd0);
        chk("abort_rx_valid", 32'(rx_got.size()) + {31'd0, rx_valid}, 32'd0);
        chk("abort_pop", 32'(pop_cnt), 32'd1);
        $display("xact abort after 5 bits abrt=%0d cmpl=%0d", abrt_cnt, cmpl_cnt);

        // Reset in the middle of a frame, then a clean frame
        @(posedge PCLK);
        tx_q.delete();
        tx_q.push_back(32'h66);
        clr_counts();
        set_mode(2'd0, 1'b0, 7);
        wait_clk(6);
        CSn = 1'b0;
        wait_clk(SETUP);
        spi_frame(32'h99, 3, scratch);
        srst = 1'b1;
        wait_clk(1);
        chk("rst_mid_flags", {23'd0, MISO, MISO_OE, tx_ready, tx_udf, rx_valid,
                              cmpl_pls, abrt_pls, rx_ovf, busy}, 32'd0);
        chk("rst_mid_rx_data", rx_data, 32'd0);
        CSn = 1'b1;
        wait_clk(4);
        srst = 1'b0;
        wait_clk(4);
        chk("rst_mid_pulses", 32'(abrt_cnt + cmpl_cnt), 32'd0);
        $display("xact reset mid-frame");
        txw[0] = 32'h96; mo_w[0] = 32'h69;
        run_burst(2'd0, 1'b0, 7, 1, 1);

        // Randomized bursts across modes, orderings and frame lengths
        for (int it = 0; it < 10; it++) begin
            logic [1:0] r_mode;
            logic       r_lsbf;
            int         r_flen;
            int         r_nf;
            int         r_ntx;
            r_mode = 2'($urandom_range(0, 3));
            r_lsbf = 1'($urandom_range(0, 1));
            r_flen = int'($urandom_range(0, 31));
            r_nf   = int'($urandom_range(1, 3));
            r_ntx  = int'($urandom_range(0, r_nf + 1));
            for (int k = 0; k < 4; k++) begin
                txw[k]  = $urandom;
                mo_w[k] = $urandom;
            end
            run_burst(r_mode, r_lsbf, r_flen, r_nf, r_ntx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slv_core.md
Name: spi_slv_core

Overview:
Parametrised next-generation SPI slave shift engine, replacing the fixed-mode SPI controller inside the SPI slave top. It supports all four CPOL/CPHA modes, MSB- or LSB-first ordering, and a runtime frame length of 1..DW bits. It oversamples SCK/CSn/MOSI in the PCLK domain and exchanges words with external TX/RX FIFOs over valid/ready handshakes. It also reports frame completion, abort, TX underrun and RX overrun as single-cycle pulses.

Parameters:
DW, 32, maximum frame width in bits (≥2); LW = $clog2(DW) is derived.
SYNC_STG, 2, synchroniser depth for SCK, CSn and MOSI (≥2).
TX_IDLE, '0, DW-bit word shifted out on TX underrun.

Ports:
PCLK  in  1  system clock; only clock in the block.
srst  in  1  synchronous reset, active-high.
cfg_en  in  1  engine enable; when low, CSn is ignored.
cfg_cpol  in  1  SCK idle level.
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
cfg_lsbf  in  1  1 = LSB first.
cfg_flen  in  LW  frame length minus 1.
SCK  in  1  SPI clock, asynchronous to PCLK.
CSn  in  1  chip select, active-low, asynchronous.
MOSI  in  1  serial data in.
MISO  out  1  serial data out.
MISO_OE  out  1  MISO output enable.
tx_data  in  DW  next TX word; right-justified.
tx_valid  in  1  TX word available.
tx_ready  out  1  TX word consumed this cycle (pop pulse).
rx_data  out  DW  received word; right-justified, upper bits zero.
rx_valid  out  1  rx_data valid.
rx_ready  in  1  downstream accepts rx_data.
cmpl_pls  out  1  frame complete.
abrt_pls  out  1  frame aborted by CSn rising mid-frame.
tx_udf  out  1  TX underrun pulse.
rx_ovf  out  1  RX overrun pulse.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (srst high at a PCLK edge): every output is 0, FSM goes to IDLE, shift registers and bit counter clear. Reset takes effect mid-frame with no pulses generated.
- Sync and edge detect: SCK, CSn and MOSI each pass through SYNC_STG flops, plus one delay flop for edge detection.
  - Pin-to-internal-event latency is SYNC_STG+1 PCLK cycles.
  - Requirement: PCLK ≥ 4× SCK, and CSn setup to the first SCK edge ≥ 4 PCLK cycles.
- Edge classification: a leading edge is a transition away from cpol; a trailing edge is a transition back to cpol. The sample edge is leading when cpha=0 and trailing when cpha=1. The other edge is the shift edge.
- Config capture: cpol, cpha, lsbf and flen are latched on the CSn-fall event in IDLE. Changes to them during a transfer are ignored.
- FSM states are IDLE, LOAD, SHIFT.
  - IDLE: MISO_OE=0. On a synced CSn fall with cfg_en=1, go to LOAD.
  - LOAD (1 cycle): if tx_valid, tx_ready=1 and the shift register loads tx_data. Otherwise tx_udf=1 and the shift register loads TX_IDLE. MISO_OE=1. Next state is SHIFT.
  - SHIFT: MISO = tx_sr[0] if lsbf, else tx_sr[flen].
    - On each sample edge: rx_sr shifts in MOSI and the bit counter increments.
    - On each shift edge: tx_sr shifts. When cpha=1, the first leading edge of each frame does not shift.
    - On the sample edge where count==flen, the frame completes: cmpl_pls=1 in the following cycle, the counter clears, and the FSM returns to LOAD for the next word. For cpha=0, LOAD is deferred to the following trailing edge so the last bit is held until then.
- RX handoff:
  - On completion with rx_valid=0, or rx_valid=1 and rx_ready=1 in the same cycle: rx_data is updated and rx_valid=1 one cycle after the completing sample edge.
  - If rx_valid=1 and rx_ready=0: rx_ovf=1, the new word is dropped and the old word is kept.
  - rx_valid clears on rx_valid & rx_ready.
- Bit ordering: MSB-first receive gives rx_data[flen:0] = bits in arrival order, first bit at bit flen. LSB-first: the first bit lands at bit 0.
- CSn rises mid-frame (count≠0 or in LOAD): abrt_pls=1, the partial RX word is discarded, the popped TX word is lost, and the FSM goes to IDLE. There is no cmpl_pls.
- CSn rises exactly after completion: the FSM goes to IDLE with no abort.
- cfg_en falling during a frame has no effect until IDLE.
- Pulse co-occurrence: cmpl_pls and rx_ovf may assert in the same cycle. tx_udf may assert in the same cycle as cmpl_pls of the previous frame.
- busy = (state≠IDLE).

Decomposition:
- Package spi_slv_pkg holds:
  - the typedef enum for the states (IDLE/LOAD/SHIFT);
  - a packed struct spi_cfg_t {cpol, cpha, lsbf, flen};
  - the localparam for the sync depth minimum.
- Sub-module spi_slv_sync: a SYNC_STG synchroniser plus edge detector, instantiated once per input. It outputs the synced level plus rise and fall pulses.

Test Plan:
- Mode 0, MSB, flen=7: master sends 0xA5 while tx_data=0x3C is valid → master reads 0x3C; rx_data=0x000000A5; one cmpl_pls; one tx_ready.
- Mode 3, LSB, flen=15: master sends 0x1234 with tx_data=0xBEEF → master reads 0xBEEF LSB-first; rx_data=0x1234.
- Back-to-back: three 8-bit frames (0x01, 0x02, 0x03) in mode 1 under one CSn, with rx_ready=1 → three cmpl_pls; rx_data sequence 0x01, 0x02, 0x03; three tx_ready pops.
- Underrun/overrun: TX_IDLE=0xFF, tx_valid=0, rx_ready=0, two 8-bit frames → tx_udf on each frame and master reads 0xFF twice; the second frame gives rx_ovf=1 and rx_data keeps the first word.
- Abort: CSn rises after 5 of 8 bits → abrt_pls=1, no cmpl_pls, rx_valid stays 0, busy=0 within SYNC_STG+2 cycles.
- Reset mid-frame: srst asserted during bit 3 → all outputs 0 on the next PCLK edge; the next full frame after release completes correctly.
